stopwatch_up: RTL and testbench
===============================

STOPWATCH_UP -- requirements
Module: stopwatch_up

Interface
- REQ-001: Parameter TICKS_PER_SEC, default 32'd50000000: clk cycles per counted second, legal range >= 2.
- REQ-002: Parameter LIMIT, default 8'd99: terminal count value, legal range 1..99.
- REQ-003: clk  input  1  the single system clock; all state changes on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: start  input  1  synchronous level, sampled every cycle; begins or resumes counting.
- REQ-006: stop  input  1  synchronous level, sampled every cycle; pauses counting.
- REQ-007: clear  input  1  synchronous level, sampled every cycle; returns the block to zero/idle.
- REQ-008: t  output  8  elapsed seconds, registered, unsigned 0..LIMIT.
- REQ-009: running  output  1  registered; high only in RUN.
- REQ-010: done  output  1  registered; high only in DONE.
- REQ-011: seg7_lsb  output  7  seven-segment pattern for the ones digit of t.
- REQ-012: seg7_msb  output  7  seven-segment pattern for the tens digit of t.

Function
- REQ-013: FSM states SHALL be IDLE, RUN, PAUSE and DONE, encoded in 2 bits.
- REQ-014: Prescaler SHALL be a 32-bit counter that increments only in RUN.
- REQ-015: Tick SHALL be the cycle in RUN where the prescaler equals TICKS_PER_SEC-1; on that edge the prescaler goes to 0 and t goes to t+1.
- REQ-016: t SHALL change only on a tick, on clear, or on start from IDLE.
- REQ-017: IDLE: start=1 -> RUN, with t=0 and prescaler=0; otherwise stay in IDLE.
- REQ-018: RUN: stop=1 -> PAUSE; the prescaler holds its value.
- REQ-019: PAUSE: start=1 -> RUN, resuming from the held prescaler value (no partial-second loss).
- REQ-020: On the tick edge where t+1 == LIMIT, the FSM SHALL go to DONE; t=LIMIT and done=1 become visible on the same edge.
- REQ-021: DONE: t holds at LIMIT, the prescaler holds, and start and stop are ignored.
- REQ-022: clear=1 in any state -> IDLE, with t=0, prescaler=0, running=0, done=0 on the next edge.
- REQ-023: Priority SHALL be clear > stop > start; start and stop together in RUN -> PAUSE, and in PAUSE -> stay in PAUSE.
- REQ-024: stop asserted on a tick cycle SHALL still apply that tick's increment, then enter PAUSE.
- REQ-025: stop asserted on the final tick cycle SHALL give DONE, because terminal count overrides pause.
- REQ-026: t SHALL never exceed LIMIT or wrap.
- REQ-027: seg7 outputs SHALL be combinational from t, show the decimal tens and ones digits, and be active-low (0 = segment on).

Reset
- REQ-028: On the rst=1 edge: state=IDLE, t=0, prescaler=0, running=0, done=0.
- REQ-029: rst SHALL override clear, start and stop in the same cycle.
- REQ-030: rst asserted mid-RUN SHALL abandon the partial second; after release, counting SHALL need start again.
- REQ-031: No asynchronous reset paths SHALL exist.

Structure
- REQ-032: The state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3) and the default TICKS_PER_SEC constant SHALL live in the shared timer package used by the other timer blocks.
- REQ-033: One sub-module SHALL be instantiated: the existing two_decimal_values (t -> seg7_lsb, seg7_msb).
- REQ-034: The FSM next-state logic and the datapath (prescaler, t) SHALL live in stopwatch_up.

Verification (TICKS_PER_SEC=4, LIMIT=5 unless stated)
- REQ-035: rst for 2 cycles, then start pulse -> running=1 on the next edge; t=1 exactly 4 cycles later; t=2 after 8.
- REQ-036: Run 6 cycles, then stop pulse -> t=1 held over 20 idle cycles; start -> t=2 exactly 2 cycles after resume.
- REQ-037: Free-run to terminal -> t=5 and done=1 on the same edge, running=0; t holds at 5; start/stop ignored for 10 cycles.
- REQ-038: start, stop and clear all high in one RUN cycle -> IDLE, t=0; in a separate case, stop on the tick cycle -> t increments and state=PAUSE.
- REQ-039: LIMIT=99, TICKS_PER_SEC=2: run to end -> done at t=99; seg7 shows 9/9; at t=10 patterns are digit 1 (msb) and digit 0 (lsb).
- REQ-040: rst asserted mid-second during RUN (t=3) -> next edge t=0, IDLE; after release, no count occurs without start.

Source files
------------

// File: rtl/stopwatch_up_pkg.sv
// Shared timer package: FSM state encodings, default timing constants and
// the seven-segment digit encoder used by the timer display blocks.
package stopwatch_up_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_TICKS_PER_SEC = 32'd50000000;
  localparam logic [7:0]  DEFAULT_LIMIT         = 8'd99;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}; non-decimal
  // inputs blank the digit.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/stopwatch_up_two_decimal_values.sv
// Splits a 0..99 binary value into tens and ones digits and drives one
// active-low seven-segment pattern per digit.
module two_decimal_values
  import stopwatch_up_pkg::*;
(
  input  logic [7:0] value,
  output logic [6:0] seg7_lsb,
  output logic [6:0] seg7_msb
);

  logic [3:0] tens;
  logic [3:0] ones;

  // Purely combinational digit split and encoding so the display tracks t
  // with no extra latency.
  always_comb begin
    tens     = 4'(value / 8'd10);
    ones     = 4'(value % 8'd10);
    seg7_msb = seg7_encode(tens);
    seg7_lsb = seg7_encode(ones);
  end

endmodule

// File: rtl/stopwatch_up.sv
// Count-up stopwatch: a prescaler divides clk down to one-second ticks,
// t counts seconds up to LIMIT, and start/stop/clear drive a four-state FSM.
module stopwatch_up
  import stopwatch_up_pkg::*;
#(
  parameter logic [31:0] TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter logic [7:0]  LIMIT         = DEFAULT_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] t,
  output logic       running,
  output logic       done,
  output logic [6:0] seg7_lsb,
  output logic [6:0] seg7_msb
);

  state_t      state;
  state_t      next_state;
  logic [31:0] presc;
  logic [31:0] next_presc;
  logic [7:0]  next_t;
  logic        tick;

  assign tick = (state == RUN) && (presc == TICKS_PER_SEC - 32'd1);

  // Next-state and datapath decisions; clear beats stop beats start, and a
  // tick's increment is always applied even if stop arrives on that cycle.
  always_comb begin
    next_state = state;
    next_presc = presc;
    next_t     = t;
    if (clear) begin
      next_state = IDLE;
      next_presc = 32'd0;
      next_t     = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = RUN;
            next_presc = 32'd0;
            next_t     = 8'd0;
          end
        end
        RUN: begin
          if (tick) begin
            next_presc = 32'd0;
            next_t     = t + 8'd1;
            if ((t + 8'd1) == LIMIT) begin
              next_state = DONE;
            end else if (stop) begin
              next_state = PAUSE;
            end
          end else if (stop) begin
            next_state = PAUSE;
          end else begin
            next_presc = presc + 32'd1;
          end
        end
        PAUSE: begin
          if (!stop && start) begin
            next_state = RUN;
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = IDLE;
          next_presc = 32'd0;
          next_t     = 8'd0;
        end
      endcase
    end
  end

  // State and datapath registers; running/done are registered from the
  // next state so they line up with t on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= 32'd0;
      t       <= 8'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      presc   <= next_presc;
      t       <= next_t;
      running <= (next_state == RUN);
      done    <= (next_state == DONE);
    end
  end

  two_decimal_values u_digits (
    .value    (t),
    .seg7_lsb (seg7_lsb),
    .seg7_msb (seg7_msb)
  );

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench: instance a uses TICKS_PER_SEC=4, LIMIT=5; instance b uses
// TICKS_PER_SEC=2, LIMIT=99 for the full-range display run.
module tb_stopwatch_up;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clear;

  logic [7:0] t_a;
  logic       running_a;
  logic       done_a;
  logic [6:0] seg7_lsb_a;
  logic [6:0] seg7_msb_a;

  logic [7:0] t_b;
  logic       running_b;
  logic       done_b;
  logic [6:0] seg7_lsb_b;
  logic [6:0] seg7_msb_b;

  int check_count;
  int fail_count;

  stopwatch_up #(.TICKS_PER_SEC(32'd4), .LIMIT(8'd5)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .t        (t_a),
    .running  (running_a),
    .done     (done_a),
    .seg7_lsb (seg7_lsb_a),
    .seg7_msb (seg7_msb_a)
  );

  stopwatch_up #(.TICKS_PER_SEC(32'd2), .LIMIT(8'd99)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .t        (t_b),
    .running  (running_b),
    .done     (done_b),
    .seg7_lsb (seg7_lsb_b),
    .seg7_msb (seg7_msb_b)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic s_start,
                               input logic s_stop, input logic s_clear);
    rst   = r;
    start = s_start;
    stop  = s_stop;
    clear = s_clear;
  endtask

  // Advance n rising edges and settle 1 unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic [7:0] exp_t,
                        input logic exp_running, input logic exp_done);
    checkOutput({tag, " t"}, 32'(t_a), 32'(exp_t));
    checkOutput({tag, " running"}, 32'(running_a), 32'(exp_running));
    checkOutput({tag, " done"}, 32'(done_a), 32'(exp_done));
  endtask

  initial begin
    check_count = 0;
    fail_count  = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;

    // Reset and first seconds
    step(2);
    checkA("reset", 8'd0, 1'b0, 1'b0);
    checkOutput("reset seg lsb", 32'(seg7_lsb_a), 32'(SEG_0));
    checkOutput("reset seg msb", 32'(seg7_msb_a), 32'(SEG_0));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checkA("start", 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    checkA("before first tick", 8'd0, 1'b1, 1'b0);
    step(1);
    checkA("first tick", 8'd1, 1'b1, 1'b0);
    step(4);
    checkA("second tick", 8'd2, 1'b1, 1'b0);

    // Pause keeps the partial second
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    checkA("clear", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(6);
    checkA("run 6", 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    checkA("stop", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(20);
    checkA("paused 20", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checkA("resume", 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    checkA("resume +1", 8'd1, 1'b1, 1'b0);
    step(1);
    checkA("resume +2", 8'd2, 1'b1, 1'b0);

    // Free run to terminal count (prescaler 0, t=2 here)
    step(11);
    checkA("before terminal", 8'd4, 1'b1, 1'b0);
    step(1);
    checkA("terminal", 8'd5, 1'b0, 1'b1);
    checkOutput("terminal seg lsb", 32'(seg7_lsb_a), 32'(SEG_5));
    checkOutput("terminal seg msb", 32'(seg7_msb_a), 32'(SEG_0));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, i[0], ~i[0], 1'b0);
      step(1);
      checkA("done hold", 8'd5, 1'b0, 1'b1);
    end

    // Clear wins over start and stop
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(5);
    checkA("pre all-high", 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    step(1);
    checkA("all high", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(5);
    checkA("idle no count", 8'd0, 1'b0, 1'b0);

    // Stop beats start in RUN and PAUSE
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    checkA("start+stop run", 8'd0, 1'b0, 1'b0);
    step(1);
    checkA("start+stop pause", 8'd0, 1'b0, 1'b0);

    // Stop on a tick cycle keeps the increment
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    checkA("stop on tick", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(8);
    checkA("stop on tick hold", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    checkA("post-tick resume", 8'd1, 1'b1, 1'b0);
    step(1);
    checkA("post-tick second", 8'd2, 1'b1, 1'b0);

    // Stop on the final tick still reaches DONE
    step(8);
    step(3);
    checkA("before final", 8'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    checkA("stop on final", 8'd5, 1'b0, 1'b1);

    // Reset mid-second overrides start
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(12);
    step(2);
    checkA("pre reset", 8'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    checkA("mid reset", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(10);
    checkA("after reset", 8'd0, 1'b0, 1'b0);

    // Full-range run on instance b
    checkOutput("b reset t", 32'(t_b), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("b running", 32'(running_b), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(20);
    checkOutput("b t10", 32'(t_b), 32'd10);
    checkOutput("b t10 seg msb", 32'(seg7_msb_b), 32'(SEG_1));
    checkOutput("b t10 seg lsb", 32'(seg7_lsb_b), 32'(SEG_0));
    step(176);
    checkOutput("b t98", 32'(t_b), 32'd98);
    checkOutput("b t98 done", 32'(done_b), 32'd0);
    step(2);
    checkOutput("b t99", 32'(t_b), 32'd99);
    checkOutput("b done", 32'(done_b), 32'd1);
    checkOutput("b done running", 32'(running_b), 32'd0);
    checkOutput("b t99 seg msb", 32'(seg7_msb_b), 32'(SEG_9));
    checkOutput("b t99 seg lsb", 32'(seg7_lsb_b), 32'(SEG_9));
    step(5);
    checkOutput("b hold", 32'(t_b), 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             check_count, fail_count);
    $finish;
  end

endmodule
